uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. The receiver emits a one-cycle `_rx_valid` pulse per byte and never honours backpressure, so this block captures every byte into a first-word-fall-through FIFO. It presents the bytes to the consumer under a valid/ready handshake. Bytes that cannot be stored are dropped and recorded by a sticky overflow flag and a saturating drop counter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 tb/tb_uart_rx_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Contents: byte type, frame length in bit times, drop-counter ceiling,
//           and a saturating increment helper for 8-bit counters.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int bits_per_byte  = 10;
  localparam int drop_count_max = 255;

  // Increment that sticks at drop_count_max instead of wrapping to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(drop_count_max)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: depth x 8 register file.
// Ports: clock; write port (we, waddr, wdata) on the rising edge;
//        asynchronous read port (raddr -> rdata). Contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int depth = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  uart_byte_t               wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output uart_byte_t               rdata
);

  uart_byte_t mem [depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver; one cycle
// from push to visibility on out. The receiver cannot be stalled, so bytes
// arriving with no space are dropped and tallied (sticky overflow flag and
// saturating drop_count). Consumer side uses a valid/ready handshake.
// Ports: clock, reset (async, active-low); in/in_valid/in_ready from the
//        receiver; out/out_valid/out_ready to the consumer; count;
//        overflow/drop_count with overflow_clear.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int depth = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  uart_byte_t               in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output uart_byte_t               out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clear,
  output logic [7:0]               drop_count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [aw-1:0] wp;
  logic [aw-1:0] rp;
  uart_byte_t    rdata;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  uart_fifo_mem #(.depth(depth)) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wp),
    .wdata (in),
    .raddr (rp),
    .rdata (rdata)
  );

  assign full      = (count == cw'(depth));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts a byte when the consumer is taking one. Held low in reset.
  assign in_ready  = reset && (!full || pop);
  assign push      = in_valid && in_ready;
  assign drop      = reset && in_valid && !in_ready;

  // Masked so a stale memory word never shows while empty.
  assign out = out_valid ? rdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wp <= wp + aw'(1);
      end
      if (pop) begin
        rp <= rp + aw'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase

      // A drop in the clearing cycle is the first drop of the new window.
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= overflow_clear ? 8'd1 : sat_inc8(drop_count);
      end else if (overflow_clear) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       overflow;
  logic       overflow_clear = 1'b0;
  logic [7:0] drop_count;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.depth(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in             (in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out            (out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus overflow state, updated per the
  // behavioural rules on each rising edge; emptied by asynchronous reset.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  int         m_dc  = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      bit pop_now, acc, drp;
      pop_now = (q.size() > 0) && out_ready;
      acc     = in_valid && ((q.size() < DEPTH) || pop_now);
      drp     = in_valid && !acc;
      if (pop_now) void'(q.pop_front());
      if (acc) q.push_back(in);
      if (drp) begin
        m_ovf = 1'b1;
        m_dc  = overflow_clear ? 1 : ((m_dc >= 255) ? 255 : m_dc + 1);
      end else if (overflow_clear) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    int exp_rdy;
    exp_rdy = (reset && ((q.size() < DEPTH) || (q.size() > 0 && out_ready))) ? 1 : 0;
    chk("cyc_count",      int'(count),      q.size());
    chk("cyc_out_valid",  int'(out_valid),  (q.size() > 0) ? 1 : 0);
    chk("cyc_out",        int'(out),        (q.size() > 0) ? int'(q[0]) : 0);
    chk("cyc_in_ready",   int'(in_ready),   exp_rdy);
    chk("cyc_overflow",   int'(overflow),   int'(m_ovf));
    chk("cyc_drop_count", int'(drop_count), m_dc);
  end

  // Apply inputs for one cycle, then land 1 time unit after the edge.
  task automatic step(input bit iv, input logic [7:0] d, input bit ordy, input bit clr);
    in_valid       = iv;
    in             = d;
    out_ready      = ordy;
    overflow_clear = clr;
    @(posedge clock);
    #1;
    in_valid       = 1'b0;
    overflow_clear = 1'b0;
  endtask

  logic [7:0] ping [4];
  int max_cnt;

  initial begin
    ping[0] = 8'h70; ping[1] = 8'h69; ping[2] = 8'h6E; ping[3] = 8'h67;

    #1 reset = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clock); #2 reset = 1'b1;
    #1 chk("rst_release_in_ready", int'(in_ready), 1);

    // "ping" held then drained.
    for (int i = 0; i < 4; i++) step(1, ping[i], 0, 0);
    chk("ping_count", int'(count), 4);
    chk("ping_head", int'(out), 8'h70);
    for (int i = 0; i < 4; i++) begin
      chk("ping_drain_valid", int'(out_valid), 1);
      chk("ping_drain_byte", int'(out), int'(ping[i]));
      step(0, 8'h00, 1, 0);
    end
    chk("ping_empty_valid", int'(out_valid), 0);
    chk("ping_empty_out", int'(out), 0);

    // Overfill by four.
    for (int i = 0; i < 20; i++) step(1, 8'(i), 0, 0);
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drops", int'(drop_count), 4);

    // Push into a full FIFO while popping.
    step(1, 8'hAA, 1, 0);
    chk("fullpop_count", int'(count), 16);
    chk("fullpop_flag", int'(overflow), 1);
    chk("fullpop_drops", int'(drop_count), 4);
    for (int i = 1; i < 16; i++) begin
      chk("ovf_drain_byte", int'(out), i);
      step(0, 8'h00, 1, 0);
    end
    chk("aa_last", int'(out), 8'hAA);
    step(0, 8'h00, 1, 0);
    chk("ovf_drain_empty", int'(out_valid), 0);

    // Clear alone, then clear colliding with a drop.
    step(0, 8'h00, 0, 1);
    chk("clr_flag", int'(overflow), 0);
    chk("clr_drops", int'(drop_count), 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'hEE, 0, 1);
    chk("clr_drop_flag", int'(overflow), 1);
    chk("clr_drop_drops", int'(drop_count), 1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    chk("clr_drain_empty", int'(count), 0);

    // 300-byte stream at full rate, exercising pointer wrap.
    max_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1, 8'(i), 1, 0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (i % 50 == 7) chk("stream_head", int'(out), i % 256);
    end
    chk("stream_max_count", max_cnt, 1);
    chk("stream_no_drops", int'(drop_count), 1);
    step(0, 8'h00, 1, 0);
    chk("stream_empty", int'(out_valid), 0);

    // Saturate the drop counter.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'h55, 0, 0);
    chk("sat_drops", int'(drop_count), 255);
    chk("sat_flag", int'(overflow), 1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);

    // Asynchronous reset mid-stream with seven bytes stored.
    for (int i = 0; i < 7; i++) step(1, 8'(8'h30 + i), 0, 0);
    chk("pre_rst_count", int'(count), 7);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out", int'(out), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_drops", int'(drop_count), 0);
    @(posedge clock); #2 reset = 1'b1;
    step(1, 8'h5A, 0, 0);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_out", int'(out), 8'h5A);
    chk("post_rst_count", int'(count), 1);
    step(0, 8'h00, 1, 0);

    @(posedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
